vend_dispense_ctrl: RTL and testbench

- Downstream actuator stage for the coin-accumulation FSM.
- Consumes its 2-bit vend code: 2'b10 means dispense; 2'b11 means dispense and return change.
- Drives the item motor and the change ejector with timed pulses, and confirms the drop via the item sensor.
- Reports completion, faults and saturating vend/change statistics to the maintenance logic.

---
 rtl/vend_dispense_ctrl.sv | 151 +++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispense_ctrl.sv
// Actuator stage behind the coin FSM: times the item motor and change ejector, confirms
// the drop through the item sensor and keeps saturating vend/change statistics.
module vend_dispense_ctrl #(
    parameter int unsigned MOTOR_CYCLES  = 8,
    parameter int unsigned SENSE_TIMEOUT = 16,
    parameter int unsigned CHANGE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       vend_code_i,
    input  logic             item_sensed_i,
    input  logic             fault_clr_i,
    output logic             motor_on_o,
    output logic             change_on_o,
    output logic             busy_o,
    output logic             vend_done_o,
    output logic             fault_o,
    output logic             dropped_req_o,
    output logic [CNT_W-1:0] vend_count_o,
    output logic [CNT_W-1:0] change_count_o
);

    localparam int unsigned TimerMax =
        (MOTOR_CYCLES > SENSE_TIMEOUT) ?
            ((MOTOR_CYCLES > CHANGE_CYCLES) ? MOTOR_CYCLES : CHANGE_CYCLES) :
            ((SENSE_TIMEOUT > CHANGE_CYCLES) ? SENSE_TIMEOUT : CHANGE_CYCLES);
    localparam int unsigned TimerW = (TimerMax > 1) ? $clog2(TimerMax) : 1;

    // Timer counts down to zero, so each phase loads its length minus one.
    localparam logic [TimerW-1:0] MotorLoad  = TimerW'(MOTOR_CYCLES - 1);
    localparam logic [TimerW-1:0] SenseLoad  = TimerW'(SENSE_TIMEOUT - 1);
    localparam logic [TimerW-1:0] ChangeLoad = TimerW'(CHANGE_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StMotor, StSense, StChange, StDone, StFault} state_e;

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                need_change_q, need_change_d;
    logic                item_seen_q, item_seen_d;
    logic                motor_on_d, change_on_d, busy_d, vend_done_d, fault_d, dropped_req_d;
    logic [CNT_W-1:0]    vend_count_d, change_count_d;
    logic                timer_zero;

    assign timer_zero = (timer_q == '0);

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        need_change_d = need_change_q;
        item_seen_d   = item_seen_q;

        case (state_q)
            StIdle: begin
                if (vend_code_i[1]) begin
                    need_change_d = vend_code_i[0];
                    item_seen_d   = 1'b0;
                    timer_d       = MotorLoad;
                    state_d       = StMotor;
                end
            end
            StMotor: begin
                if (item_sensed_i) item_seen_d = 1'b1;
                if (timer_zero) begin
                    if (item_seen_q || item_sensed_i) begin
                        if (need_change_q) begin
                            state_d = StChange;
                            timer_d = ChangeLoad;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        state_d = StSense;
                        timer_d = SenseLoad;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StSense: begin
                // A sensor hit on the expiry edge still counts as a good drop.
                if (item_sensed_i) begin
                    if (need_change_q) begin
                        state_d = StChange;
                        timer_d = ChangeLoad;
                    end else begin
                        state_d = StDone;
                    end
                end else if (timer_zero) begin
                    state_d = StFault;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StChange: begin
                if (timer_zero) state_d = StDone;
                else            timer_d = timer_q - 1'b1;
            end
            StDone:  state_d = StIdle;
            StFault: if (fault_clr_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered images of the next state.
    always_comb begin
        motor_on_d     = (state_d == StMotor);
        change_on_d    = (state_d == StChange);
        busy_d         = (state_d != StIdle);
        vend_done_d    = (state_d == StDone);
        fault_d        = (state_d == StFault);
        dropped_req_d  = vend_code_i[1] && (state_q != StIdle);
        vend_count_d   = vend_count_o;
        change_count_d = change_count_o;
        if (state_d == StDone) begin
            if (vend_count_o != '1) vend_count_d = vend_count_o + 1'b1;
            if (need_change_q && (change_count_o != '1)) change_count_d = change_count_o + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            timer_q        <= '0;
            need_change_q  <= 1'b0;
            item_seen_q    <= 1'b0;
            motor_on_o     <= 1'b0;
            change_on_o    <= 1'b0;
            busy_o         <= 1'b0;
            vend_done_o    <= 1'b0;
            fault_o        <= 1'b0;
            dropped_req_o  <= 1'b0;
            vend_count_o   <= '0;
            change_count_o <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            need_change_q  <= need_change_d;
            item_seen_q    <= item_seen_d;
            motor_on_o     <= motor_on_d;
            change_on_o    <= change_on_d;
            busy_o         <= busy_d;
            vend_done_o    <= vend_done_d;
            fault_o        <= fault_d;
            dropped_req_o  <= dropped_req_d;
            vend_count_o   <= vend_count_d;
            change_count_o <= change_count_d;
        end
    end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: directed scenarios plus randomized vends checked against
// a timeline model built from phase lengths.
module tb_vend_dispense_ctrl;

    localparam int M = 8;
    localparam int S = 16;
    localparam int C = 4;
    localparam int W = 8;
    localparam int LIM = 30;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   vend_code;
    logic         item_sensed;
    logic         fault_clr;
    logic         motor_on, change_on, busy, vend_done, fault, dropped_req;
    logic [W-1:0] vend_count, change_count;

    logic [1:0]   vend_code_s;
    logic         item_sensed_s;
    logic         fault_clr_s;
    logic         motor_on_s, change_on_s, busy_s, vend_done_s, fault_s, dropped_req_s;
    logic [1:0]   vend_count_s, change_count_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference statistics and expected timeline of the most recent vend.
    int rm_vend = 0;
    int rm_chg  = 0;
    int e_done, e_c_cnt, e_c_first, e_fault, e_blow;

    // Observed timeline, indexed by edges after the request edge (edge 0).
    int m_first, m_last, m_cnt, c_first, c_cnt, d_idx, d_cnt, f_idx, b_low, dr_idx, dr_cnt;

    always #5 clk = ~clk;

    vend_dispense_ctrl #(
        .MOTOR_CYCLES (M),
        .SENSE_TIMEOUT(S),
        .CHANGE_CYCLES(C),
        .CNT_W        (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vend_code_i   (vend_code),
        .item_sensed_i (item_sensed),
        .fault_clr_i   (fault_clr),
        .motor_on_o    (motor_on),
        .change_on_o   (change_on),
        .busy_o        (busy),
        .vend_done_o   (vend_done),
        .fault_o       (fault),
        .dropped_req_o (dropped_req),
        .vend_count_o  (vend_count),
        .change_count_o(change_count)
    );

    vend_dispense_ctrl #(
        .MOTOR_CYCLES (2),
        .SENSE_TIMEOUT(2),
        .CHANGE_CYCLES(1),
        .CNT_W        (2)
    ) dut_s (
        .clk           (clk),
        .rst           (rst),
        .vend_code_i   (vend_code_s),
        .item_sensed_i (item_sensed_s),
        .fault_clr_i   (fault_clr_s),
        .motor_on_o    (motor_on_s),
        .change_on_o   (change_on_s),
        .busy_o        (busy_s),
        .vend_done_o   (vend_done_s),
        .fault_o       (fault_s),
        .dropped_req_o (dropped_req_s),
        .vend_count_o  (vend_count_s),
        .change_count_o(change_count_s)
    );

    // sense_at: edge on which item_sensed is high (0 = never); inject_at: extra 10 code edge.
    task automatic run_vend(input logic [1:0] code, input int sense_at, input int inject_at);
        m_first = -1; m_last = -1; m_cnt = 0; c_first = -1; c_cnt = 0;
        d_idx = -1; d_cnt = 0; f_idx = -1; b_low = -1; dr_idx = -1; dr_cnt = 0;
        @(negedge clk);
        vend_code   = code;
        item_sensed = 1'b0;
        for (int j = 0; j <= LIM; j++) begin
            @(posedge clk);
            #1;
            vend_code   = (inject_at == j + 1) ? 2'b10 : 2'b00;
            item_sensed = (sense_at == j + 1);
            if (motor_on) begin
                if (m_first < 0) m_first = j;
                m_last = j;
                m_cnt++;
            end
            if (change_on) begin
                if (c_first < 0) c_first = j;
                c_cnt++;
            end
            if (vend_done) begin
                if (d_idx < 0) d_idx = j;
                d_cnt++;
            end
            if (fault && f_idx < 0) f_idx = j;
            if (!busy && b_low < 0) b_low = j;
            if (dropped_req) begin
                if (dr_idx < 0) dr_idx = j;
                dr_cnt++;
            end
        end
        vend_code   = 2'b00;
        item_sensed = 1'b0;
    endtask

    // Phase-length model: M motor cycles, optional sense wait, optional C change cycles.
    task automatic model_vend(input bit chg, input int sense_at);
        int sc;
        int cc;
        if (sense_at >= 1 && sense_at <= M + S) begin
            sc        = (sense_at <= M) ? 0 : sense_at - M;
            cc        = chg ? C : 0;
            e_done    = M + sc + cc;
            e_c_cnt   = cc;
            e_c_first = chg ? M + sc : -1;
            e_fault   = -1;
            e_blow    = e_done + 1;
            rm_vend++;
            if (chg) rm_chg++;
        end else begin
            e_done    = -1;
            e_c_cnt   = 0;
            e_c_first = -1;
            e_fault   = M + S;
            e_blow    = -1;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({motor_on, change_on, busy, vend_done, fault, dropped_req} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {motor_on, change_on, busy, vend_done, fault, dropped_req});
        end
        n_checks++;
        if (vend_count !== 0 || change_count !== 0) begin
            n_fail++;
            $display("FAIL reset_counts: got %0d/%0d expected 0/0", vend_count, change_count);
        end
    endtask

    task automatic test_vend_no_change();
        run_vend(2'b10, 3, 0);
        model_vend(1'b0, 3);
        n_checks++;
        if (m_first !== 0 || m_cnt !== M || m_last !== M - 1) begin
            n_fail++;
            $display("FAIL nochg_motor: got first %0d cnt %0d expected 0 %0d", m_first, m_cnt, M);
        end
        n_checks++;
        if (c_cnt !== 0) begin
            n_fail++;
            $display("FAIL nochg_change: got %0d cycles expected 0", c_cnt);
        end
        n_checks++;
        if (d_idx !== e_done || d_cnt !== 1 || b_low !== e_blow) begin
            n_fail++;
            $display("FAIL nochg_done: got done %0d x%0d busy_low %0d expected %0d x1 %0d",
                     d_idx, d_cnt, b_low, e_done, e_blow);
        end
        n_checks++;
        if (vend_count !== rm_vend || change_count !== rm_chg) begin
            n_fail++;
            $display("FAIL nochg_counts: got %0d/%0d expected %0d/%0d",
                     vend_count, change_count, rm_vend, rm_chg);
        end
    endtask

    task automatic test_vend_change();
        run_vend(2'b11, M + 5, 0);
        model_vend(1'b1, M + 5);
        n_checks++;
        if (m_cnt !== M || c_first !== e_c_first || c_cnt !== e_c_cnt) begin
            n_fail++;
            $display("FAIL chg_timeline: got motor %0d change %0d@%0d expected %0d %0d@%0d",
                     m_cnt, c_cnt, c_first, M, e_c_cnt, e_c_first);
        end
        n_checks++;
        if (d_idx !== e_done || d_cnt !== 1) begin
            n_fail++;
            $display("FAIL chg_done: got %0d x%0d expected %0d x1", d_idx, d_cnt, e_done);
        end
        n_checks++;
        if (vend_count !== rm_vend || change_count !== rm_chg) begin
            n_fail++;
            $display("FAIL chg_counts: got %0d/%0d expected %0d/%0d",
                     vend_count, change_count, rm_vend, rm_chg);
        end
    endtask

    task automatic test_timeout_fault();
        run_vend(2'b11, 0, 0);
        model_vend(1'b1, 0);
        n_checks++;
        if (f_idx !== e_fault || c_cnt !== 0 || d_cnt !== 0 || m_cnt !== M) begin
            n_fail++;
            $display("FAIL fault_timeline: got fault@%0d change %0d done %0d expected %0d 0 0",
                     f_idx, c_cnt, d_cnt, e_fault);
        end
        n_checks++;
        if (vend_count !== rm_vend || change_count !== rm_chg) begin
            n_fail++;
            $display("FAIL fault_counts: got %0d/%0d expected %0d/%0d",
                     vend_count, change_count, rm_vend, rm_chg);
        end
        @(negedge clk);
        vend_code = 2'b10;
        @(posedge clk);
        #1;
        vend_code = 2'b00;
        n_checks++;
        if (dropped_req !== 1'b1 || fault !== 1'b1 || motor_on !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_drop: got drop %b fault %b motor %b expected 1 1 0",
                     dropped_req, fault, motor_on);
        end
        @(posedge clk);
        #1;
        fault_clr = 1'b1;
        n_checks++;
        if (dropped_req !== 1'b0 || fault !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_hold: got drop %b fault %b expected 0 1", dropped_req, fault);
        end
        @(posedge clk);
        #1;
        fault_clr = 1'b0;
        n_checks++;
        if (fault !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_clear: got fault %b busy %b expected 0 0", fault, busy);
        end
    endtask

    task automatic test_busy_reject();
        run_vend(2'b10, 3, 2);
        model_vend(1'b0, 3);
        n_checks++;
        if (dr_cnt !== 1 || dr_idx !== 2) begin
            n_fail++;
            $display("FAIL reject_drop: got %0d pulses @%0d expected 1 @2", dr_cnt, dr_idx);
        end
        n_checks++;
        if (d_cnt !== 1 || vend_count !== rm_vend) begin
            n_fail++;
            $display("FAIL reject_single: got done %0d count %0d expected 1 %0d",
                     d_cnt, vend_count, rm_vend);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vend_code = k[1:0];
            @(posedge clk);
            #1;
            vend_code = 2'b00;
            @(posedge clk);
            #1;
            n_checks++;
            if (busy !== 1'b0 || dropped_req !== 1'b0 || motor_on !== 1'b0) begin
                n_fail++;
                $display("FAIL ignore_code%0d: got busy %b drop %b motor %b expected 0 0 0",
                         k, busy, dropped_req, motor_on);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            bit chg;
            int sa;
            chg = 1'($urandom_range(0, 1));
            sa  = $urandom_range(0, M + S);
            run_vend({1'b1, chg}, sa, 0);
            model_vend(chg, sa);
            n_checks++;
            if (m_cnt !== M || d_idx !== e_done || c_cnt !== e_c_cnt || c_first !== e_c_first ||
                f_idx !== e_fault || b_low !== e_blow || dr_cnt !== 0) begin
                n_fail++;
                $display("FAIL rand%0d chg %0d sense %0d: got m%0d d%0d c%0d@%0d f%0d b%0d dr%0d expected m%0d d%0d c%0d@%0d f%0d b%0d dr0",
                         i, chg, sa, m_cnt, d_idx, c_cnt, c_first, f_idx, b_low, dr_cnt,
                         M, e_done, e_c_cnt, e_c_first, e_fault, e_blow);
            end
            n_checks++;
            if (vend_count !== rm_vend || change_count !== rm_chg) begin
                n_fail++;
                $display("FAIL rand%0d_counts: got %0d/%0d expected %0d/%0d",
                         i, vend_count, change_count, rm_vend, rm_chg);
            end
            if (e_fault >= 0) begin
                @(negedge clk);
                fault_clr = 1'b1;
                @(negedge clk);
                fault_clr = 1'b0;
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 6; i++) begin
            bit seen;
            seen = 1'b0;
            @(negedge clk);
            vend_code_s   = 2'b11;
            item_sensed_s = 1'b1;
            @(posedge clk);
            #1;
            vend_code_s = 2'b00;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(posedge clk);
                #1;
                if (vend_done_s) seen = 1'b1;
            end
            item_sensed_s = 1'b0;
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL sat_done%0d: got no vend_done expected pulse within 20 cycles", i);
            end
            n_checks++;
            if (vend_count_s !== ((i < 3) ? i : 3) || change_count_s !== ((i < 3) ? i : 3)) begin
                n_fail++;
                $display("FAIL sat_count%0d: got %0d/%0d expected %0d", i,
                         vend_count_s, change_count_s, (i < 3) ? i : 3);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        vend_code = 2'b10;
        @(posedge clk);
        #1;
        vend_code = 2'b00;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (motor_on !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_motor: got %b expected 1", motor_on);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({motor_on, change_on, busy, vend_done, fault, dropped_req} !== 6'b0 ||
            vend_count !== 0 || change_count !== 0 || vend_count_s !== 0) begin
            n_fail++;
            $display("FAIL async_reset: got outs %b counts %0d/%0d expected 000000 0/0",
                     {motor_on, change_on, busy, vend_done, fault, dropped_req},
                     vend_count, change_count);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || motor_on !== 1'b0 || vend_count !== 0 || change_count !== 0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got busy %b motor %b counts %0d/%0d expected 0 0 0/0",
                     busy, motor_on, vend_count, change_count);
        end
    endtask

    initial begin
        rst           = 1'b1;
        vend_code     = 2'b00;
        item_sensed   = 1'b0;
        fault_clr     = 1'b0;
        vend_code_s   = 2'b00;
        item_sensed_s = 1'b0;
        fault_clr_s   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_vend_no_change();
        test_vend_change();
        test_timeout_fault();
        test_busy_reject();
        test_random();
        test_saturation();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
